// File: rtl/pad_cell_input_filter.sv
// Multi-channel input pad cell: raw pass-through, optional inversion, synchroniser,
// debounce/glitch filter with a runtime threshold, and registered rise/fall pulses.
module pad_cell_input_filter #(
    parameter int unsigned NUM_PADS    = 4,
    parameter int unsigned PADATTR     = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    inout  wire  [NUM_PADS-1:0]                pad_io,
    input  logic [NUM_PADS-1:0][PADATTR-1:0]   pad_attributes_i,
    output logic [NUM_PADS-1:0]                pad_raw_o,
    output logic [NUM_PADS-1:0]                pad_out_o,
    output logic [NUM_PADS-1:0]                rise_o,
    output logic [NUM_PADS-1:0]                fall_o
);

    localparam int unsigned ATTR_FILT_EN = 0;
    localparam int unsigned ATTR_INVERT  = 1;
    localparam int unsigned ATTR_RISE_EN = 2;
    localparam int unsigned ATTR_FALL_EN = 3;
    localparam int unsigned ATTR_THR_LSB = 8;

    logic [NUM_PADS-1:0]                  filt_en, invert, rise_en, fall_en;
    logic [NUM_PADS-1:0][CNT_W-1:0]       thr;
    logic [NUM_PADS-1:0]                  din, sync_out;
    logic [NUM_PADS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_PADS-1:0]                  q_q, q_d;
    logic [NUM_PADS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_PADS-1:0]                  rise_q, rise_d, fall_q, fall_d;

    // Reserved and out-of-range attribute bits are intentionally ignored.
    logic unused_attr_bits;
    assign unused_attr_bits = ^pad_attributes_i;

    assign pad_raw_o = pad_io;

    always_comb begin
        for (int i = 0; i < int'(NUM_PADS); i++) begin
            filt_en[i] = pad_attributes_i[i][ATTR_FILT_EN];
            invert[i]  = pad_attributes_i[i][ATTR_INVERT];
            rise_en[i] = pad_attributes_i[i][ATTR_RISE_EN];
            fall_en[i] = pad_attributes_i[i][ATTR_FALL_EN];
            thr[i]     = pad_attributes_i[i][ATTR_THR_LSB +: CNT_W];
            // Inversion sits ahead of the synchroniser so toggling it is filtered like an edge.
            din[i]      = pad_io[i] ^ invert[i];
            sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], din[i]};
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    always_comb begin
        q_d    = q_q;
        cnt_d  = '0;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < int'(NUM_PADS); i++) begin
            if (!filt_en[i]) begin
                q_d[i] = sync_out[i];
            end else if (sync_out[i] != q_q[i]) begin
                // >= rather than == so a lowered threshold commits on the next cycle.
                if (cnt_q[i] >= thr[i]) begin
                    q_d[i] = sync_out[i];
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    cnt_d[i] = cnt_q[i];
                end
            end
            rise_d[i] = rise_en[i] & ~q_q[i] &  q_d[i];
            fall_d[i] = fall_en[i] &  q_q[i] & ~q_d[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pad_out_o = q_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;

endmodule

// File: tb/tb_pad_cell_input_filter.sv
// Self-checking bench for pad_cell_input_filter: directed scenarios plus randomized
// traffic, all checked every cycle against a history-based behavioural model.
module tb_pad_cell_input_filter;

    localparam int NUM_PADS    = 4;
    localparam int PADATTR     = 16;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic                             clk;
    logic                             rst_n;
    logic [NUM_PADS-1:0]              pad_drv;
    wire  [NUM_PADS-1:0]              pad_w;
    logic [NUM_PADS-1:0][PADATTR-1:0] attr;
    logic [NUM_PADS-1:0]              pad_raw, pad_out, rise, fall;

    assign pad_w = pad_drv;

    pad_cell_input_filter #(
        .NUM_PADS(NUM_PADS), .PADATTR(PADATTR), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .pad_io           (pad_w),
        .pad_attributes_i (attr),
        .pad_raw_o        (pad_raw),
        .pad_out_o        (pad_out),
        .rise_o           (rise),
        .fall_o           (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: a delay line for the synchroniser, then the debounce rule stated
    // over the history of synchronised samples: commit once the trailing run of samples
    // disagreeing with the filtered level exceeds thr.
    bit dl [NUM_PADS][SYNC_STAGES];
    bit sh [NUM_PADS][$];
    bit mq [NUM_PADS];
    bit mr [NUM_PADS];
    bit mf [NUM_PADS];

    function automatic logic [PADATTR-1:0] mk(bit fen, bit inv, bit re, bit fe, int thr);
        logic [PADATTR-1:0] a;
        a = '0;
        a[0] = fen;
        a[1] = inv;
        a[2] = re;
        a[3] = fe;
        a[8 +: CNT_W] = CNT_W'(thr);
        return a;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_PADS; c++) begin
            for (int k = 0; k < SYNC_STAGES; k++) dl[c][k] = 1'b0;
            sh[c].delete();
            mq[c] = 1'b0;
            mr[c] = 1'b0;
            mf[c] = 1'b0;
        end
    endtask

    task automatic step();
        logic [NUM_PADS-1:0] e_out, e_rise, e_fall;
        @(posedge clk);
        for (int c = 0; c < NUM_PADS; c++) begin
            bit s, nq;
            int run, thr;
            s = dl[c][SYNC_STAGES-1];
            for (int k = SYNC_STAGES-1; k > 0; k--) dl[c][k] = dl[c][k-1];
            dl[c][0] = pad_drv[c] ^ attr[c][1];
            sh[c].push_back(s);
            if (sh[c].size() > 400) void'(sh[c].pop_front());
            run = 0;
            for (int k = sh[c].size()-1; k >= 0; k--) begin
                if (sh[c][k] == mq[c]) break;
                run++;
            end
            thr = int'(attr[c][8 +: CNT_W]);
            nq = mq[c];
            if (!attr[c][0] || run > thr) nq = s;
            mr[c] = attr[c][2] & !mq[c] &  nq;
            mf[c] = attr[c][3] &  mq[c] & !nq;
            mq[c] = nq;
        end
        #1;
        for (int c = 0; c < NUM_PADS; c++) begin
            e_out[c]  = mq[c];
            e_rise[c] = mr[c];
            e_fall[c] = mf[c];
        end
        check("pad_out", 32'(pad_out), 32'(e_out));
        check("rise",    32'(rise),    32'(e_rise));
        check("fall",    32'(fall),    32'(e_fall));
        check("pad_raw", 32'(pad_raw), 32'(pad_drv));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int lat, cnt, seen;

        // Reset with pads high
        rst_n   = 1'b0;
        pad_drv = 4'b1111;
        attr[0] = mk(0, 0, 1, 0, 0);
        attr[1] = mk(0, 0, 0, 0, 0);
        attr[2] = mk(0, 0, 1, 0, 0);
        attr[3] = mk(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out",  32'(pad_out), 32'h0);
        check("rst_rise", 32'(rise),    32'h0);
        check("rst_fall", 32'(fall),    32'h0);
        check("rst_raw",  32'(pad_raw), 32'hf);
        #3 rst_n = 1'b1;
        steps(2);
        check("rel_out_early", 32'(pad_out), 32'h0);
        step();
        check("rel_out_3", 32'(pad_out), 32'hf);
        check("rel_rise_3", 32'(rise), 32'h5);
        step();
        check("rel_rise_once", 32'(rise), 32'h0);

        // Debounce on ch0, thr=5
        attr[0] = mk(0, 0, 0, 0, 0);
        pad_drv[0] = 1'b0;
        steps(6);
        attr[0] = mk(1, 0, 1, 0, 5);
        pad_drv[0] = 1'b1;
        lat = -1; cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pad_out[0] && lat < 0) lat = k;
            cnt += int'(rise[0]);
        end
        check("debounce_latency", 32'(lat), 32'd8);
        check("debounce_rise_cnt", 32'(cnt), 32'd1);

        // Glitch rejection: 4-cycle pulses against thr=5
        attr[0] = mk(0, 0, 0, 0, 0);
        pad_drv[0] = 1'b0;
        steps(6);
        attr[0] = mk(1, 0, 1, 1, 5);
        cnt = 0; seen = 0;
        for (int r = 0; r < 10; r++) begin
            pad_drv[0] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step(); seen += int'(pad_out[0]); cnt += int'(rise[0]) + int'(fall[0]);
            end
            pad_drv[0] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                step(); seen += int'(pad_out[0]); cnt += int'(rise[0]) + int'(fall[0]);
            end
        end
        steps(6);
        check("glitch_level", 32'(seen), 32'd0);
        check("glitch_events", 32'(cnt), 32'd0);

        // Invert toggling on ch1, fall events only
        pad_drv[1] = 1'b0;
        attr[1] = mk(0, 0, 0, 1, 0);
        steps(6);
        attr[1] = mk(0, 1, 0, 1, 0);
        cnt = 0;
        steps(2);
        check("inv_out_early", 32'(pad_out[1]), 32'd0);
        cnt += int'(rise[1]);
        step();
        cnt += int'(rise[1]);
        check("inv_out_3", 32'(pad_out[1]), 32'd1);
        steps(3);
        cnt += int'(rise[1]);
        check("inv_no_rise", 32'(cnt), 32'd0);
        attr[1] = mk(0, 0, 0, 1, 0);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(); cnt += int'(fall[1]);
        end
        check("inv_fall_cnt", 32'(cnt), 32'd1);
        check("inv_out_back", 32'(pad_out[1]), 32'd0);

        // Maximum threshold on ch2
        attr[2] = mk(1, 0, 0, 1, 255);
        pad_drv[2] = 1'b0;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (!pad_out[2] && lat < 0) lat = k;
        end
        check("thr255_latency", 32'(lat), 32'd258);

        // Threshold lowered mid-count on ch3
        attr[3] = mk(1, 0, 0, 0, 200);
        pad_drv[3] = 1'b0;
        steps(102);
        check("thr_rewrite_hold", 32'(pad_out[3]), 32'd1);
        attr[3] = mk(1, 0, 0, 0, 10);
        step();
        check("thr_rewrite_commit", 32'(pad_out[3]), 32'd0);

        // Async reset mid-count on ch0 with other channels high
        attr[2] = mk(0, 0, 0, 0, 0);
        attr[3] = mk(0, 0, 0, 0, 0);
        pad_drv[2] = 1'b1;
        pad_drv[3] = 1'b1;
        steps(6);
        check("pre_rst_out", 32'(pad_out), 32'hc);
        pad_drv[0] = 1'b1;
        steps(5);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(pad_out), 32'h0);
        check("async_rst_ev", 32'({rise, fall}), 32'h0);
        #1 rst_n = 1'b1;
        model_reset();
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (pad_out[0] && lat < 0) lat = k;
        end
        check("async_rst_recount", 32'(lat), 32'd8);

        // Randomized traffic, including reserved-bit noise
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < NUM_PADS; c++) begin
                if ($urandom_range(5) == 0) pad_drv[c] = ~pad_drv[c];
                if ($urandom_range(63) == 0) begin
                    attr[c] = mk(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                                 int'($urandom_range(6)));
                    attr[c][7:4] = 4'($urandom);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pad_cell_input_filter.md
Name: pad_cell_input_filter

Overview:
- Parametrised multi-channel input pad cell for FPGA targets; successor to the single-bit combinational input pad.
- Per pad: raw pass-through, optional inversion, N-stage synchroniser, programmable debounce/glitch filter, and rise/fall event pulses.
- Sits between the top-level pad ring and pad_control/GPIO, which drives pad_attributes_i.

Parameters:
- NUM_PADS, 4, number of independent input channels.
- PADATTR, 16, attribute bits per pad; must be >= 8 + CNT_W.
- SYNC_STAGES, 2, synchroniser flop count; must be >= 2.
- CNT_W, 8, debounce counter width; threshold range 0..2^CNT_W-1.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- pad_io  inout  NUM_PADS  physical pad; only read, never driven.
- pad_attributes_i  input  NUM_PADS x PADATTR  per-pad config: [0] filt_en, [1] invert, [2] rise_en, [3] fall_en, [7:4] reserved, [8+CNT_W-1:8] thr.
- pad_raw_o  input-path output  NUM_PADS  combinational copy of pad_io, unsynchronised (legacy pad_out_o behaviour).
- pad_out_o  output  NUM_PADS  synchronised, filtered level.
- rise_o  output  NUM_PADS  one-cycle pulse on filtered 0->1.
- fall_o  output  NUM_PADS  one-cycle pulse on filtered 1->0.

Behaviour:
- Reset (async assert, sync release via clk_i): sync chain, q (filtered level), counter, rise_o, fall_o all 0. pad_out_o = 0. Reset mid-count discards the count.
- Inversion: d = pad_io ^ invert, applied before the synchroniser. Toggling invert is treated as an input change and passes through the filter.
- Synchroniser: s = d delayed SYNC_STAGES clocks. No reset-value glitch: all stages reset to 0.
- Filter, per channel, one register stage:
  - filt_en = 0: q <= s every cycle; counter held at 0.
  - filt_en = 1, s == q: counter <= 0.
  - filt_en = 1, s != q, counter >= thr: q <= s, counter <= 0.
  - filt_en = 1, s != q, counter < thr: counter <= counter + 1. Saturates at 2^CNT_W-1; never wraps.
- Debounce semantics: a level differing from q for thr+1 consecutive cycles at s commits. Any bounce back to q restarts the count. thr = 0 is identical to filt_en = 0.
- Latency, input edge to pad_out_o: SYNC_STAGES + 1 + thr cycles (3 + thr at defaults).
- Runtime thr change uses the >= compare, so lowering thr below the current count commits on the next cycle. Clearing filt_en mid-count commits s next cycle.
- pad_out_o = q.
- Event pulses are registered, not combinational:
  - rise_o <= rise_en & ~q & q_next.
  - fall_o <= fall_en & q & ~q_next.
  - Each pulse is high for exactly one cycle, the same cycle pad_out_o first shows the new value.
  - rise_o and fall_o are never high together on one channel.
  - Disabled events are never reported later.
- Channels are fully independent; reserved attribute bits and bits above 8+CNT_W-1 are ignored.
- pad_io is never driven (tri-state only). pad_raw_o has zero latency.

Test Plan:
- Reset: hold rst_ni=0 with pad_io=4'b1111 -> pad_out_o, rise_o, fall_o = 0 and pad_raw_o = 4'b1111. Release; filt_en=0 -> pad_out_o=1 exactly 3 cycles later, rise_o pulses that cycle only if rise_en=1.
- Debounce: ch0 filt_en=1, thr=5, pad 0->1 held -> pad_out_o[0] rises 8 cycles after the edge; rise_o[0] high exactly 1 cycle.
- Glitch rejection: thr=5, pulses high for 4 cycles then low, repeated 10 times -> pad_out_o[0] stays 0, no rise_o or fall_o.
- Invert/events: ch1 invert toggled 0->1 with pad=0, fall_en=1, rise_en=0 -> pad_out_o[1] 0->1 after 3 cycles, no rise_o. Invert back -> fall_o[1] pulses once.
- Threshold edge cases: thr=255 with input held 300 cycles -> commits at cycle 258, counter does not wrap. Mid-count (count=100) thr rewritten to 10 -> commit on the next cycle.
- Async reset mid-count: rst_ni pulsed low for a sub-cycle width at count=3 -> counter and pad_out_o clear immediately with no clock edge needed. After release, the full thr+1 count is required again.
